// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchroniser plus persistence filter for one I2C line; emits the filtered level
// and single-cycle rise/fall pulses coincident with the level flip.
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Flip on the FILT_LEN-th consecutive disagreeing sample.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                fall_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder on a fixed 7-bit address: filtered SCL/SDA decode, byte-wide
// write delivery (rx_*) and read supply (tx_*), open-drain SDA pull-down request.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       stop_evt
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic       start_det;
    logic       stop_det;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic       phase_q;
    logic       rw_q;
    logic       wr_first_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_first_q;
    logic       tx_req_q;
    logic       stop_evt_q;

    assign byte_in = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            wr_first_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_evt_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_evt_q <= 1'b0;
            if (stop_det) begin
                state_q    <= ST_IDLE;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                stop_evt_q <= 1'b1;
                bitcnt_q   <= '0;
                phase_q    <= 1'b0;
            end else if (start_det) begin
                state_q  <= ST_ADDR;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
                phase_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q  <= byte_in;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_q    <= ST_ADDR_ACK;
                                    busy_q     <= 1'b1;
                                    rw_q       <= sda_lvl;
                                    wr_first_q <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    // phase_q: 0 = waiting for the fall that starts the ACK bit, 1 = ACK driven.
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= ~ACK;
                                phase_q  <= 1'b1;
                            end else begin
                                phase_q  <= 1'b0;
                                bitcnt_q <= '0;
                                if (state_q == ST_ADDR_ACK && rw_q == RW_READ) begin
                                    shift_q  <= tx_data;
                                    sda_oe_q <= ~tx_data[7];
                                    state_q  <= ST_RD_DATA;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= ST_WR_DATA;
                                end
                            end
                        end else if (scl_rise && phase_q && state_q == ST_ADDR_ACK && rw_q == RW_READ) begin
                            tx_req_q <= 1'b1;
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_q  <= byte_in;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                rx_data_q  <= byte_in;
                                rx_valid_q <= 1'b1;
                                rx_first_q <= wr_first_q;
                                wr_first_q <= 1'b0;
                                state_q    <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bitcnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= '0;
                                phase_q  <= 1'b0;
                                state_q  <= ST_RD_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                                bitcnt_q <= bitcnt_q + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && !phase_q) begin
                            if (sda_lvl == NACK) begin
                                state_q  <= ST_WAIT_STOP;
                                sda_oe_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else begin
                                tx_req_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q  <= 1'b0;
                            shift_q  <= tx_data;
                            sda_oe_q <= ~tx_data[7];
                            bitcnt_q <= '0;
                            state_q  <= ST_RD_DATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_q;
    assign stop_evt = stop_evt_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master over an open-drain bus model, with
// expected write bytes and read bytes derived from the transactions it issues.
module tb_i2c_target;

    localparam int H = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, rx_first, tx_req, busy, stop_evt;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] rx_q[$];
    logic [8:0] exp_rx[$];
    logic [7:0] txv[4];
    int         tx_req_cnt = 0;
    int         stop_cnt   = 0;
    bit         oe_seen    = 0;
    bit         busy_seen  = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h50), .FILT_LEN(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_first(rx_first),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .busy    (busy),
        .stop_evt(stop_evt)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back({rx_first, rx_data});
        if (tx_req) tx_req_cnt++;
        if (stop_evt) stop_cnt++;
        if (sda_oe) oe_seen = 1;
        if (busy) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; clks(H);
        scl_m = 1'b1; clks(H);
        sda_m = 1'b0; clks(H);
        scl_m = 1'b0; clks(H / 2);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; clks(H / 2);
        scl_m = 1'b1; clks(H);
        sda_m = 1'b1; clks(H);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    clks(H / 2);
        scl_m = 1'b1; clks(H);
        scl_m = 1'b0; clks(H / 2);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; clks(H / 2);
        scl_m = 1'b1; clks(H / 2);
        b = sda_bus;  clks(H / 2);
        scl_m = 1'b0; clks(H / 2);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic rd_byte(input logic [7:0] next_tx, input logic mack, output logic [7:0] got);
        logic bv;
        got = '0;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            got = {got[6:0], bv};
            if (i == 7) tx_data = 8'($urandom);
        end
        tx_data = next_tx;
        write_bit(mack);
    endtask

    task automatic write_xfer(input logic [6:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input int n);
        logic       ack;
        logic       match;
        logic [7:0] d;
        match = (addr == 7'h50);
        m_start();
        wr_byte({addr, 1'b0}, ack);
        check("addr_ack", ack, match ? 0 : 1);
        check("busy_after_addr", busy, match);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            wr_byte(d, ack);
            check("data_ack", ack, match ? 0 : 1);
            if (match) exp_rx.push_back({(i == 0), d});
        end
    endtask

    task automatic read_xfer(input int n, input logic busy_at_start);
        logic       ack;
        logic [7:0] got;
        int         req0;
        req0 = tx_req_cnt;
        tx_data = txv[0];
        m_start();
        check("busy_at_start", busy, busy_at_start);
        wr_byte({7'h50, 1'b1}, ack);
        check("rd_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            rd_byte((i + 1 < n) ? txv[i + 1] : 8'h00, (i == n - 1), got);
            check("rd_byte", got, txv[i]);
        end
        check("tx_req_cnt", tx_req_cnt - req0, n);
        clks(5);
        check("oe_after_nack", sda_oe, 0);
        check("busy_after_nack", busy, 0);
    endtask

    task automatic cmp_rx();
        check("rx_count", rx_q.size(), exp_rx.size());
        while (exp_rx.size() > 0 && rx_q.size() > 0) begin
            check("rx_byte", rx_q.pop_front(), exp_rx.pop_front());
        end
        rx_q.delete();
        exp_rx.delete();
    endtask

    initial begin
        int   s0;
        int   n;
        logic ack;

        clks(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_stop_evt", stop_evt, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        clks(10);

        // Plain write of two bytes.
        s0 = stop_cnt;
        write_xfer(7'h50, 8'h12, 8'h34, 8'h00, 2);
        m_stop(); clks(5);
        check("wr_stop_evt", stop_cnt - s0, 1);
        check("wr_busy_end", busy, 0);
        cmp_rx();

        // Foreign address: never touch SDA.
        oe_seen = 0; busy_seen = 0;
        write_xfer(7'h51, 8'hA2, 8'h00, 8'h00, 1);
        check("nomatch_oe_seen", oe_seen, 0);
        check("nomatch_busy_seen", busy_seen, 0);
        s0 = stop_cnt;
        m_stop(); clks(5);
        check("nomatch_stop_evt", stop_cnt - s0, 1);
        cmp_rx();

        // Read two bytes, ACK then NACK.
        txv[0] = 8'hA5; txv[1] = 8'h3C;
        read_xfer(2, 1'b0);
        m_stop(); clks(5);

        // Write then repeated START into a read.
        write_xfer(7'h50, 8'h07, 8'h00, 8'h00, 1);
        txv[0] = 8'h96;
        read_xfer(1, 1'b1);
        m_stop(); clks(5);
        cmp_rx();

        // SDA glitches with SCL high.
        s0 = stop_cnt;
        sda_m = 1'b0; clks(2); sda_m = 1'b1; clks(20);
        check("glitch2_stop", stop_cnt - s0, 0);
        oe_seen = 0;
        wr_byte({7'h50, 1'b0}, ack);
        check("glitch2_no_ack", ack, 1);
        check("glitch2_oe_seen", oe_seen, 0);
        m_stop(); clks(5);
        s0 = stop_cnt;
        sda_m = 1'b0; clks(5); sda_m = 1'b1; clks(20);
        check("pulse5_stop", stop_cnt - s0, 1);
        check("pulse5_busy", busy, 0);

        // Randomised transactions.
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                write_xfer(7'h50, 8'($urandom), 8'($urandom), 8'($urandom), n);
                m_stop(); clks(5);
                cmp_rx();
            end else begin
                for (int k = 0; k < 4; k++) txv[k] = 8'($urandom);
                read_xfer(n, 1'b0);
                m_stop(); clks(5);
            end
        end

        // Asynchronous reset while the target pulls SDA low.
        tx_data = 8'h00;
        m_start();
        wr_byte({7'h50, 1'b1}, ack);
        check("rst_rd_addr_ack", ack, 0);
        clks(10);
        check("rst_oe_before", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_oe_async", sda_oe, 0);
        sda_m = 1'b1; scl_m = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(10);
        check("rst_busy_after", busy, 0);
        rx_q.delete();
        write_xfer(7'h50, 8'($urandom), 8'h00, 8'h00, 1);
        m_stop(); clks(5);
        cmp_rx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
